multi_sel_rx: RTL

//   Receive-side checker/decoder for the 4-phase multiply stream from multi_sel.

---
 rtl/multi_sel_rx.sv | 130 +++++++++++++
 1 files changed

// File: rtl/multi_sel_rx.sv
// rtl/multi_sel_rx.sv - receive checker/decoder for the {d, 3d, 7d, 8d} multiply stream
module multi_sel_rx #(
    parameter int DW    = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_grant,
    input  logic [DW+2:0]    in_data,
    input  logic             clr_err,
    output logic [DW-1:0]    data_out,
    output logic             data_vld,
    output logic             err,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        HUNT,
        P1,
        P2,
        P3,
        P0
    } state_t;

    state_t        state;
    logic [DW-1:0] d_cap;
    logic          bad;

    logic [DW+2:0] d_ext;
    logic [DW+2:0] exp1;
    logic [DW+2:0] exp2;
    logic [DW+2:0] exp3;
    logic [DW+2:0] exp_cur;
    logic          word_ok;
    logic          err_next;

    // 3*d and 7*d built from shifts and adds; DW+3 bits hold 8*d without overflow
    assign d_ext = {3'b000, d_cap};
    assign exp1  = d_ext + (d_ext << 1);
    assign exp2  = exp1 + (d_ext << 2);
    assign exp3  = d_ext << 3;

    always_comb begin
        exp_cur = exp1;
        case (state)
            P2:      exp_cur = exp2;
            P3:      exp_cur = exp3;
            default: exp_cur = exp1;
        endcase
    end

    assign word_ok = (in_data == exp_cur);

    // An early grant and a mismatch on the same word still make a single pulse
    always_comb begin
        err_next = 1'b0;
        case (state)
            P1, P2, P3: err_next = in_grant | ~word_ok;
            P0:         err_next = ~in_grant;
            default:    err_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HUNT;
            d_cap    <= '0;
            bad      <= 1'b0;
            data_out <= '0;
            data_vld <= 1'b0;
            err      <= 1'b0;
            locked   <= 1'b0;
            err_cnt  <= '0;
        end else begin
            data_vld <= 1'b0;
            err      <= err_next;

            if (clr_err)
                err_cnt <= '0;
            else if (err_next && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;

            case (state)
                HUNT: begin
                    if (in_grant) begin
                        d_cap <= in_data[DW-1:0];
                        bad   <= |in_data[DW+2:DW];
                        state <= P1;
                    end
                end
                P0: begin
                    if (in_grant) begin
                        d_cap <= in_data[DW-1:0];
                        bad   <= |in_data[DW+2:DW];
                        state <= P1;
                    end else begin
                        locked <= 1'b0;
                        state  <= HUNT;
                    end
                end
                P1, P2, P3: begin
                    if (in_grant) begin
                        d_cap  <= in_data[DW-1:0];
                        bad    <= |in_data[DW+2:DW];
                        locked <= 1'b0;
                        state  <= P1;
                    end else begin
                        if (!word_ok)
                            bad <= 1'b1;
                        case (state)
                            P1:      state <= P2;
                            P2:      state <= P3;
                            default: begin
                                state <= P0;
                                if (!bad && word_ok) begin
                                    data_out <= d_cap;
                                    data_vld <= 1'b1;
                                    locked   <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule
